div_iter: RTL and testbench
===========================

# div_iter

Iterative radix-2 divider in the EXE stage that executes MIPS DIV/DIVU and produces the quotient (LO) and remainder (HI). It consumes the leading-zero count of the dividend magnitude, computed in CLZ mode by the EXE bit-count block. That count skips leading-zero iterations, so latency scales with the dividend's significant bits. EXE stalls on `busy`, and the HI/LO write path consumes the results on `done`.

## Interface
- No parameters (data width fixed at 32).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; captured with `start`.
- `dividend`  in  32  captured with `start`.
- `divisor`  in  32  captured with `start`.
- `flush`  in  1  pipeline flush; aborts any operation.
- `busy`  out  1  high in PREP, ITER and FIX.
- `done`  out  1  one-cycle pulse in DONE; results valid on this cycle.
- `quotient`  out  32  LO result; held until the next `done`.
- `remainder`  out  32  HI result; held until the next `done`.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE:
  - `start`=1 and `flush`=0: register operands and `is_signed`, go to PREP.
  - Otherwise DONE returns to IDLE.
- PREP:
  - Magnitudes: |dividend| and |divisor| if signed, raw values otherwise.
  - lz = CLZ(|dividend|), range 0..32. N = 32 - lz.
  - Load partial remainder = 0 and shift register = |dividend| << lz (33-bit shift; lz=32 gives 0). Set iteration counter = N.
  - |divisor|==0: go to FIX with the div0 flag set.
  - Else N==0: go to FIX.
  - Else go to ITER.
- ITER, one quotient bit per cycle:
  - rem' = {rem[31:0], shift msb}, then trial subtract of |divisor| in 33 bits.
  - If the result is non-negative, rem takes it and a 1 is shifted into the quotient; else a 0 is shifted in.
  - Decrement the counter; at 1, go to FIX.
- FIX:
  - Signed: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Div0: quotient = 32'hFFFF_FFFF, remainder = dividend, for both signed and unsigned.
  - Register outputs, go to DONE.
- 32'h8000_0000 / -1, signed: quotient = 32'h8000_0000, remainder = 0. No trap.
- `flush`=1 in any state: next state IDLE. `done` is not asserted, and `quotient`/`remainder` keep their previous values.
- `flush` and `start` in the same cycle: `flush` wins and the start is dropped.
- `start` in PREP/ITER/FIX is ignored. EXE must not issue it while `busy`=1.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `quotient`=0, `remainder`=0. Reset mid-operation discards all work.
- Start sampled at cycle T: PREP at T+1, ITER at T+2..T+1+N, FIX at T+2+N, DONE (`done`=1) at T+3+N.
- Latency from `start` to `done`: N+3 cycles.
  - Minimum 3 cycles: dividend 0 or divisor 0.
  - Maximum 35 cycles: dividend MSB set, N=32.
- Back-to-back: `start` on the DONE cycle gives PREP on the next cycle, with no IDLE bubble.
- Outputs are registered and change only on the cycle entering DONE.

## Structure
- Shared EXE package:
  - `div_state_t` enum (IDLE, PREP, ITER, FIX, DONE).
  - Constant `DIV0_QUOTIENT` = 32'hFFFF_FFFF.
- One sub-module: the existing bit-count block instantiated with `option`=0 (CLZ) on |dividend|. Its output is used in PREP only.
- Datapath: 33-bit remainder, 32-bit shift/quotient register, 6-bit counter, sign flags.

## Test plan
- DIVU 100 / 7 at T: `done` at T+10 (N=7), quotient=14, remainder=2, `busy` high T+1..T+9.
- DIV -7 / 2: quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1). DIV 7 / -2: quotient=-3, remainder=1.
- DIVU 5 / 0 and DIV 0 / 3:
  - 5 / 0: `done` at T+3, quotient=32'hFFFF_FFFF, remainder=5.
  - 0 / 3: `done` at T+3, quotient=0, remainder=0.
- DIVU 32'hFFFF_FFFF / 1: `done` at T+35, quotient=32'hFFFF_FFFF, remainder=0. DIV 32'h8000_0000 / -1: quotient=32'h8000_0000, remainder=0.
- `flush` at T+5 during DIVU 32'hFFFF_0000 / 3: IDLE at T+6, no `done`, outputs unchanged. `start`+`flush` together: no operation starts.
- `start` on the DONE cycle of 100/7 with 9/3: the second `done` arrives 7 cycles later (N=4) with quotient=3, remainder=0. `rst` at ITER returns all outputs to 0.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared EXE definitions for the iterative divider and the bit-count block.
// Holds the divider state encoding, result constants and operand helpers.
package div_iter_pkg;

   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } div_state_t;

   localparam logic [DW-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   localparam logic BCNT_CLZ = 1'b0;
   localparam logic BCNT_POP = 1'b1;

   // Two's-complement magnitude; 32'h8000_0000 maps to itself, which is
   // exactly the unsigned magnitude the divider core needs.
   function automatic logic [DW-1:0] mag32(
      input logic [DW-1:0] v,
      input logic          sgn
   );
      return (sgn && v[DW-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/div_iter_bcnt.sv
// EXE bit-count block: leading-zero count or population count of a word.
// Result range is 0..32 in both modes.
module div_iter_bcnt
   import div_iter_pkg::*;
(
   input  logic [DW-1:0] data_i,
   input  logic          option_i,
   output logic [5:0]    count_o
);

   logic [5:0] clz;
   logic [5:0] pop;

   always_comb begin
      clz = 6'd32;
      for (int i = 0; i < DW; i++) begin
         if (data_i[i]) begin
            clz = 6'(31 - i);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < DW; i++) begin
         pop = pop + {5'd0, data_i[i]};
      end
   end

   assign count_o = (option_i == BCNT_POP) ? pop : clz;

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 DIV/DIVU unit for EXE; leading dividend zeros are
// skipped so latency tracks the dividend's significant bit count.
module div_iter
   import div_iter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          is_signed,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   input  logic          flush,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder
);

   div_state_t    state_q;
   logic          sgn_q;
   logic [DW-1:0] dvd_q;
   logic [DW-1:0] dvs_q;
   logic [DW-1:0] rem_q;
   logic [DW-1:0] sh_q;
   logic [5:0]    cnt_q;
   logic          div0_q;
   logic          busy_q;
   logic          done_q;
   logic [DW-1:0] quo_q;
   logic [DW-1:0] rmd_q;

   logic [DW-1:0] dvd_mag;
   logic [DW-1:0] dvs_mag;
   logic [5:0]    lz;
   logic [5:0]    n_bits;
   logic [DW-1:0] sh_init;
   logic [DW:0]   rem_sh;
   logic [DW:0]   trial;
   logic          q_bit;
   logic [DW-1:0] rem_d;
   logic [DW-1:0] sh_d;
   logic          q_neg;
   logic          r_neg;
   logic [DW-1:0] quo_d;
   logic [DW-1:0] rmd_d;

   assign dvd_mag = mag32(dvd_q, sgn_q);
   assign dvs_mag = mag32(dvs_q, sgn_q);

   div_iter_bcnt u_clz (
      .data_i   (dvd_mag),
      .option_i (BCNT_CLZ),
      .count_o  (lz)
   );

   assign n_bits = 6'd32 - lz;

   // lz == 32 only for a zero dividend; the shifted value is then empty.
   assign sh_init = lz[5] ? '0 : (dvd_mag << lz[4:0]);

   assign rem_sh = {rem_q, sh_q[DW-1]};
   assign trial  = rem_sh - {1'b0, dvs_mag};
   assign q_bit  = ~trial[DW];
   assign rem_d  = q_bit ? trial[DW-1:0] : rem_sh[DW-1:0];
   assign sh_d   = {sh_q[DW-2:0], q_bit};

   assign q_neg = sgn_q & (dvd_q[DW-1] ^ dvs_q[DW-1]);
   assign r_neg = sgn_q & dvd_q[DW-1];

   always_comb begin
      quo_d = q_neg ? -sh_q : sh_q;
      rmd_d = r_neg ? -rem_q : rem_q;
      if (div0_q) begin
         quo_d = DIV0_QUOTIENT;
         rmd_d = dvd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sgn_q   <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         div0_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  sgn_q   <= is_signed;
                  dvd_q   <= dividend;
                  dvs_q   <= divisor;
                  busy_q  <= 1'b1;
                  state_q <= PREP;
               end else begin
                  state_q <= IDLE;
               end
            end
            PREP: begin
               rem_q  <= '0;
               sh_q   <= sh_init;
               cnt_q  <= n_bits;
               div0_q <= (dvs_mag == '0);
               if (dvs_mag == '0 || n_bits == 6'd0) begin
                  state_q <= FIX;
               end else begin
                  state_q <= ITER;
               end
            end
            ITER: begin
               rem_q <= rem_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q - 6'd1;
               if (cnt_q == 6'd1) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quo_q   <= quo_d;
               rmd_q   <= rmd_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rmd_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and random checks of div_iter against an arithmetic reference.
// Latency is modelled from the dividend's significant bit count.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic        flush;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbits(input logic [31:0] m);
      int n = 0;
      while (m != 0) begin
         m = m >> 1;
         n++;
      end
      return n;
   endfunction

   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input bit s, output logic [31:0] q,
                                 output logic [31:0] r, output int lat);
      longint la, lb;
      logic [31:0] ma;
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         lat = 3;
         return;
      end
      la = s ? longint'($signed(a)) : longint'({32'b0, a});
      lb = s ? longint'($signed(b)) : longint'({32'b0, b});
      q = 32'(la / lb);
      r = 32'(la % lb);
      ma = (s && a[31]) ? -a : a;
      lat = nbits(ma) + 3;
   endfunction

   // Entered and left on a falling edge; leaves on the done cycle so a
   // following call issues its start back-to-back.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input logic [31:0] eq, input logic [31:0] er,
                         input int elat);
      int lat = 0;
      int bb = 0;
      dividend = a;
      divisor = b;
      is_signed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            lat = i;
            if (busy) bb++;
            break;
         end
         if (!busy) bb++;
         @(negedge clk);
      end
      chk({tag, ".lat"}, lat, elat);
      chk({tag, ".busy"}, bb, 0);
      chk({tag, ".q"}, quotient, eq);
      chk({tag, ".r"}, remainder, er);
   endtask

   initial begin
      logic [31:0] q0, r0, eq, er, a, b;
      int elat, dcnt;
      bit s;

      rst = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      is_signed = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.q", quotient, 0);
      chk("rst.r", remainder, 0);
      rst = 1'b0;
      @(negedge clk);

      run_op("u100_7", 100, 7, 0, 14, 2, 10);
      run_op("b2b9_3", 9, 3, 0, 3, 0, 7);
      @(negedge clk);
      chk("hold.done", done, 0);
      chk("hold.q", quotient, 3);
      run_op("sm7_2", -32'sd7, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6);
      @(negedge clk);
      run_op("s7_m2", 7, -32'sd2, 1, 32'hFFFF_FFFD, 1, 6);
      @(negedge clk);
      run_op("u5_0", 5, 0, 0, 32'hFFFF_FFFF, 5, 3);
      @(negedge clk);
      run_op("s0_3", 0, 3, 1, 0, 0, 3);
      @(negedge clk);
      run_op("sm5_0", -32'sd5, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 3);
      @(negedge clk);
      run_op("uffff_1", 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 35);
      @(negedge clk);
      run_op("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 35);
      @(negedge clk);

      q0 = quotient;
      r0 = remainder;
      dividend = 32'hFFFF_0000;
      divisor = 3;
      is_signed = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush.busy", busy, 0);
      dcnt = 0;
      repeat (40) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("flush.done", dcnt, 0);
      chk("flush.q", quotient, q0);
      chk("flush.r", remainder, r0);

      dividend = 100;
      divisor = 7;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy || done) dcnt++;
         @(negedge clk);
      end
      chk("stflush.act", dcnt, 0);

      dividend = 32'hFFFF_FFFF;
      divisor = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.q", quotient, 0);
      chk("midrst.r", remainder, 0);
      @(negedge clk);
      chk("midrst.idle", busy, 0);

      for (int k = 0; k < 40; k++) begin
         a = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) a = -a;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) b = -b;
         s = bit'($urandom_range(0, 1));
         model(a, b, s, eq, er, elat);
         run_op($sformatf("rnd%0d", k), a, b, s, eq, er, elat);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
